regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised multi-port register file for the pipelined core; successor to the single-write, two-read, negedge register file.
- Adds configurable width/depth/read-port count, a second write port, and a per-register scoreboard (busy bits) for hazard detection by the ID stage.
- Sits between ID (reads, issue) and WB (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk  in  1  core clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  busy bit of the addressed register, combinational
wr_en  in  2  write enables, write ports 0 and 1
wr_addr  in  2*ADDR_W  packed write addresses
wr_data  in  2*DATA_W  packed write data
iss_en  in  1  issue: mark iss_addr busy (pending write)
iss_addr  in  ADDR_W  destination of the issuing instruction
any_busy  out  1  OR of all busy bits

Behaviour:
- Reset (async, rst=1): reg[i] = i zero-extended to DATA_W (reg0 = 0); all busy bits 0; outputs follow combinationally (rd_busy=0, any_busy=0).
- Release of rst is synchronous to clk; no state changes until the first posedge with rst=0.
- Write: on posedge, wr_en[p]=1 stores wr_data[p] into reg[wr_addr[p]].
  - Both ports target the same address: port 1 wins.
  - ZERO_REG=1: writes to address 0 are dropped; reg0 reads 0.
- Read: rd_data[k] = reg[rd_addr[k]]; zero-latency, no clock.
- Scoreboard, per register on posedge:
  - Busy set by iss_en at iss_addr.
  - Busy cleared by wr_en[p] at that address.
  - Set and clear of the same register in one cycle: set wins (new producer issued).
  - ZERO_REG=1: busy[0] is never set.
  - Issue to an already-busy register keeps it busy; no counter, one pending writer per register.
- rd_busy[k] = busy[rd_addr[k]], with bypass adjustment (see Optional Feature).
- Out-of-range parameters (NUM_RD outside 1..4) are a static error: $error at elaboration.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - rd_data[k] returns the in-flight wr_data when wr_en[p] and wr_addr[p]==rd_addr[k] in the same cycle; port 1 has priority over port 0.
  - rd_busy[k] is forced 0 in that case unless iss_en targets the same address.
  - Address 0 is never bypassed when ZERO_REG=1.
- Undefined:
  - Reads return the stored value; a write becomes visible the cycle after the posedge.
  - rd_busy reflects stored busy bits only.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W defaults, reset-value function (index to DATA_W), typedefs for reg_addr_t and reg_data_t.
- One natural sub-module: regfile_sb_scoreboard (busy-bit array, set/clear priority, rd_busy/any_busy lookup); the data array stays in the top.

Test Plan:
- Reset: assert rst mid-cycle with reg5 previously written 0xDEAD -> immediately rd_data(addr 5)=5, all rd_busy=0, any_busy=0.
- Dual write collision: wr_en=2'b11, both addr 7, data0=0x11, data1=0x22 -> next cycle reg7 reads 0x22.
- Zero register: ZERO_REG=1; write 0xFFFF to addr 0 and issue addr 0 -> reads 0, rd_busy=0, any_busy=0.
- Scoreboard: issue addr 3 -> next cycle rd_busy=1 for addr 3; wr_en[0] at addr 3 with simultaneous issue addr 3 -> stays busy; later write only -> busy clears.
- Bypass: REGFILE_SB_BYPASS_EN defined, reg9 busy, write 0xABCD to addr 9 while reading 9 -> same cycle rd_data=0xABCD, rd_busy=0. Without the macro -> old value, rd_busy=1; 0xABCD appears the next cycle.
- Param sweep: NUM_RD=4, ADDR_W=3, DATA_W=16 -> four independent reads of addrs 0..3 return 0,1,2,3 after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default widths and reset-value helper for the regfile_sb register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_MAX = 64;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Each register comes out of reset holding its own index, which makes bring-up reads self-identifying.
  function automatic logic [DATA_W_MAX-1:0] reset_value(input int unsigned idx);
    return DATA_W_MAX'(idx);
  endfunction
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-writer flag per register, set on issue, cleared on write-back.
// Optional: REGFILE_SB_BYPASS_EN hides the busy flag of a register being written this cycle.
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [1:0]               wr_en_i,
  input  logic [2*ADDR_W-1:0]      wr_addr_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic                     any_busy_o
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             iss_ok;

  assign iss_ok = iss_en_i && !((ZERO_REG != 0) && (iss_addr_i == '0));

  // Clears first, then the set, so a new producer issued in the write-back cycle stays pending.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < 2; p++) begin
      if (wr_en_i[p]) busy_d[wr_addr_i[p*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_ok) busy_d[iss_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign any_busy_o = |busy_q;

  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy_o[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_SB_BYPASS_EN
      if (((wr_en_i[0] && wr_addr_i[0 +: ADDR_W] == rd_addr_i[k*ADDR_W +: ADDR_W]) ||
           (wr_en_i[1] && wr_addr_i[ADDR_W +: ADDR_W] == rd_addr_i[k*ADDR_W +: ADDR_W])) &&
          !((ZERO_REG != 0) && (rd_addr_i[k*ADDR_W +: ADDR_W] == '0)) &&
          !(iss_en_i && iss_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W]))
        rd_busy_o[k] = 1'b0;
`endif
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-write, NUM_RD-read register file with per-register busy scoreboard.
// Optional: define REGFILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = $bits(reg_data_t),
  parameter int ADDR_W   = $bits(reg_addr_t),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [1:0]               wr_en_i,
  input  logic [2*ADDR_W-1:0]      wr_addr_i,
  input  logic [2*DATA_W-1:0]      wr_data_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic                     any_busy_o
);
  localparam int DEPTH = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_sb: NUM_RD=%0d outside 1..4", NUM_RD);
  end

  logic [DATA_W-1:0] reg_q [DEPTH];
  logic [DATA_W-1:0] reg_d [DEPTH];

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    reg_d = reg_q;
    for (int p = 0; p < 2; p++) begin
      if (wr_en_i[p] && !is_zero_reg(wr_addr_i[p*ADDR_W +: ADDR_W]))
        reg_d[wr_addr_i[p*ADDR_W +: ADDR_W]] = wr_data_i[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) reg_q[i] <= DATA_W'(reset_value(i));
    end else begin
      reg_q <= reg_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_o[k*DATA_W +: DATA_W] = reg_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_SB_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        if (wr_en_i[p] && !is_zero_reg(rd_addr_i[k*ADDR_W +: ADDR_W]) &&
            wr_addr_i[p*ADDR_W +: ADDR_W] == rd_addr_i[k*ADDR_W +: ADDR_W])
          rd_data_o[k*DATA_W +: DATA_W] = wr_data_i[p*DATA_W +: DATA_W];
      end
`endif
    end
  end

  regfile_sb_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_addr_i (rd_addr_i),
    .rd_busy_o (rd_busy_o),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .iss_en_i  (iss_en_i),
    .iss_addr_i(iss_addr_i),
    .any_busy_o(any_busy_o)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default instance plus a NUM_RD=4, ADDR_W=3, DATA_W=16, ZERO_REG=0 sweep instance.
module tb_regfile_sb;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        any_busy;

  logic [11:0] s_rd_addr;
  logic [63:0] s_rd_data;
  logic [3:0]  s_rd_busy;
  logic [1:0]  s_wr_en;
  logic [5:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic        s_iss_en;
  logic [2:0]  s_iss_addr;
  logic        s_any_busy;

  regfile_sb dut (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .iss_en_i(iss_en),
    .iss_addr_i(iss_addr), .any_busy_o(any_busy)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data), .rd_busy_o(s_rd_busy),
    .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data), .iss_en_i(s_iss_en),
    .iss_addr_i(s_iss_addr), .any_busy_o(s_any_busy)
  );

  typedef struct {
    int          sel;
    int          k;
    logic [31:0] d;
    logic        b;
    logic        a;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ad;
    logic        ab;
    logic        aa;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel == 0) begin
        ad = rd_data[e.k*32 +: 32];
        ab = rd_busy[e.k];
        aa = any_busy;
      end else begin
        ad = {16'h0, s_rd_data[e.k*16 +: 16]};
        ab = s_rd_busy[e.k];
        aa = s_any_busy;
      end
      check({e.name, ".data"}, ad, e.d);
      check({e.name, ".rd_busy"}, {31'h0, ab}, {31'h0, e.b});
      check({e.name, ".any_busy"}, {31'h0, aa}, {31'h0, e.a});
    end
  end

  task automatic push(input int sel, input int k, input logic [31:0] d,
                      input logic b, input logic a, input string name);
    exp_t e;
    e.sel = sel; e.k = k; e.d = d; e.b = b; e.a = a; e.name = name;
    q.push_back(e);
  endtask

  task automatic idle();
    wr_en = '0; iss_en = 1'b0; s_wr_en = '0; s_iss_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = 5'(a);
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic iss(input int a);
    iss_en = 1'b1;
    iss_addr = 5'(a);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; iss_addr = '0;
    s_wr_addr = '0; s_wr_data = '0; s_iss_addr = '0;
    s_rd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    set_rd(5, 31);
    push(0, 0, 32'd5, 1'b0, 1'b0, "rst_r5");
    push(0, 1, 32'd31, 1'b0, 1'b0, "rst_r31");
    for (int k = 0; k < 4; k++) push(1, k, 32'(k), 1'b0, 1'b0, "sweep_rst");

    step(); rst = 1'b0;
    wr(0, 5, 32'hDEAD); iss(12);

    step(); set_rd(5, 12);
    push(0, 0, 32'hDEAD, 1'b0, 1'b1, "wr_r5");
    push(0, 1, 32'd12, 1'b1, 1'b1, "iss_r12");

    step(); rst = 1'b1;
    push(0, 0, 32'd5, 1'b0, 1'b0, "async_rst_r5");
    push(0, 1, 32'd12, 1'b0, 1'b0, "async_rst_r12");

    step(); rst = 1'b0;
    wr(0, 7, 32'h11); wr(1, 7, 32'h22);

    step(); set_rd(7, 0);
    push(0, 0, 32'h22, 1'b0, 1'b0, "collision_r7");
    push(0, 1, 32'h0, 1'b0, 1'b0, "r0_before_write");
    wr(0, 0, 32'hFFFF); iss(0);

    step(); set_rd(0, 0);
    push(0, 0, 32'h0, 1'b0, 1'b0, "zero_r0_p0");
    push(0, 1, 32'h0, 1'b0, 1'b0, "zero_r0_p1");
    iss(3);

    step(); set_rd(3, 0);
    wr(0, 3, 32'h33); iss(3);
    push(0, 0, BYP ? 32'h33 : 32'h3, 1'b1, 1'b1, "sb_set_and_clear");

    step(); set_rd(3, 0);
    wr(1, 3, 32'h44);
    push(0, 0, BYP ? 32'h44 : 32'h33, BYP ? 1'b0 : 1'b1, 1'b1, "sb_write_only");

    step(); set_rd(3, 9);
    push(0, 0, 32'h44, 1'b0, 1'b0, "sb_cleared_r3");
    push(0, 1, 32'd9, 1'b0, 1'b0, "r9_before_issue");
    iss(9);

    step(); set_rd(3, 9);
    wr(0, 9, 32'hABCD);
    push(0, 1, BYP ? 32'hABCD : 32'd9, BYP ? 1'b0 : 1'b1, 1'b1, "bypass_r9");

    step(); set_rd(20, 9);
    push(0, 1, 32'hABCD, 1'b0, 1'b0, "after_wr_r9");
    wr(0, 20, 32'h111); wr(1, 20, 32'h222);
    push(0, 0, BYP ? 32'h222 : 32'd20, 1'b0, 1'b0, "bypass_prio_r20");
    s_iss_en = 1'b1; s_iss_addr = 3'd0;

    step(); set_rd(20, 9);
    push(0, 0, 32'h222, 1'b0, 1'b0, "prio_r20");
    s_wr_en = 2'b01; s_wr_addr[2:0] = 3'd0; s_wr_data[15:0] = 16'h5A5A;
    push(1, 0, BYP ? 32'h5A5A : 32'h0, BYP ? 1'b0 : 1'b1, 1'b1, "sweep_busy_r0");

    step();
    push(1, 0, 32'h5A5A, 1'b0, 1'b0, "sweep_wr_r0");
    for (int k = 1; k < 4; k++) push(1, k, 32'(k), 1'b0, 1'b0, "sweep_rd");

    step();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
